// File: rtl/data_mem_stage.sv
// Memory-access stage: multi-cycle load/store on a little-endian byte memory,
// or ALU pass-through, with valid/ready handshakes on both sides.
module data_mem_stage #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] ALUOut,
   input  logic [31:0] ReadData2,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [4:0]  WriteReg,
   input  logic        RegWrite,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] WriteData,
   output logic [4:0]  WriteReg_out,
   output logic        RegWrite_out,
   output logic        misaligned
);
   // state  | meaning
   // IDLE   | waiting for an op, in_ready=1
   // ACCESS | memory op in flight, counter running down to 0
   // RESP   | response presented, waiting for out_ready
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q, a1, a2, a3;
   logic [31:0]           data_q, load_val;
   logic [1:0]            size_q;
   logic                  signed_q, store_q;
   logic                  accept, mem_op, unaligned, fault, commit;
   logic [7:0]            b0, b1, b2, b3;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == RESP);
   assign accept    = in_valid & in_ready;
   assign mem_op    = MemRead | MemWrite;
   assign fault     = mem_op & unaligned;
   assign commit    = (state == ACCESS) && (cnt == '0);

   always_comb begin
      unaligned = 1'b0;
      case (MemSize)
         2'b00:   unaligned = 1'b0;
         2'b01:   unaligned = ALUOut[0];
         default: unaligned = |ALUOut[1:0];
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (mem_op && !fault) ? ACCESS : RESP;
         ACCESS:  if (cnt == '0) state_nxt = RESP;
         RESP:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // byte addresses wrap modulo the memory depth
   assign a1 = addr_q + ADDR_WIDTH'(1);
   assign a2 = addr_q + ADDR_WIDTH'(2);
   assign a3 = addr_q + ADDR_WIDTH'(3);
   assign b0 = mem[addr_q];
   assign b1 = mem[a1];
   assign b2 = mem[a2];
   assign b3 = mem[a3];

   always_comb begin
      load_val = {b3, b2, b1, b0};
      case (size_q)
         2'b00:   load_val = signed_q ? {{24{b0[7]}}, b0} : {24'h0, b0};
         2'b01:   load_val = signed_q ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
         default: load_val = {b3, b2, b1, b0};
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt          <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         store_q      <= 1'b0;
         WriteData    <= '0;
         WriteReg_out <= '0;
         RegWrite_out <= 1'b0;
         misaligned   <= 1'b0;
      end else if (accept) begin
         cnt          <= CW'(LATENCY - 1);
         addr_q       <= ALUOut[ADDR_WIDTH-1:0];
         data_q       <= ReadData2;
         size_q       <= MemSize;
         signed_q     <= MemSigned;
         store_q      <= MemWrite;
         WriteData    <= mem_op ? 32'h0 : ALUOut;
         WriteReg_out <= WriteReg;
         RegWrite_out <= RegWrite & ~fault & ~MemWrite;
         misaligned   <= fault;
      end else if (state == ACCESS) begin
         if (cnt == '0) begin
            if (!store_q) WriteData <= load_val;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // memory has no reset; an abandoned op never reaches commit since state resets
   always_ff @(posedge CLK) begin
      if (commit && store_q) begin
         mem[addr_q] <= data_q[7:0];
         if (size_q != 2'b00) mem[a1] <= data_q[15:8];
         if (size_q[1]) begin
            mem[a2] <= data_q[23:16];
            mem[a3] <= data_q[31:24];
         end
      end
   end
endmodule
